uart_rfg_cmd_decoder: RTL

Byte-stream command decoder placed directly downstream of the UART AXI-Stream driver's receive master port. It consumes raw received bytes, parses them into framed register-access commands (header, length, optional write data) and emits one register command per addressed byte on a valid/ready command port toward the register file. A mid-frame inter-byte timeout aborts stuck frames so a lost byte cannot desynchronise the link.

---
 rtl/uart_rfg_pkg.sv | 19 +
 rtl/uart_rfg_cmd_decoder_if.sv | 31 +++
 rtl/uart_gap_timer.sv | 37 +++
 rtl/uart_rfg_cmd_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_rfg_pkg.sv
// Shared definitions for the UART register-frame command decoder:
// header field positions, FSM state encoding and frame byte type.
package uart_rfg_pkg;

    localparam int unsigned WRITE_BIT = 7;
    localparam int unsigned INC_BIT   = 6;
    localparam int unsigned ADDR_MSB  = 5;

    typedef logic [7:0]        frame_byte_t;
    typedef logic [ADDR_MSB:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/uart_rfg_cmd_decoder_if.sv
// Byte-stream input and register-command output of the frame decoder.
// The master modport is the byte source / command sink side.
interface uart_rfg_cmd_decoder_if #(
    parameter int unsigned ID_WIDTH = 8
);
    import uart_rfg_pkg::*;

    frame_byte_t         s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [ID_WIDTH-1:0] s_axis_tid;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    reg_addr_t           cmd_addr;
    frame_byte_t         cmd_wdata;
    logic                cmd_last;
    logic [ID_WIDTH-1:0] cmd_id;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tid, cmd_ready,
        input  s_axis_tready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_last, cmd_id
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tid, cmd_ready,
        output s_axis_tready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_last, cmd_id
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags the cycle in which the TIMEOUT_CYCLES-th idle cycle occurs.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic resn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // count_q holds the idle cycles already elapsed, so this cycle is the last allowed one
    assign expired = enable && !clear && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rfg_cmd_decoder.sv
// Parses header/length/data byte frames into per-register commands with a
// valid/ready command port; aborts frames stalled on the byte side.
module uart_rfg_cmd_decoder
    import uart_rfg_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   resn,
    uart_rfg_cmd_decoder_if.slave  bus,
    output logic                   frame_error,
    output logic                   busy
);
    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                inc_q, inc_d;
    reg_addr_t           addr_q, addr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    frame_byte_t         wdata_q, wdata_d;
    frame_byte_t         rem_q, rem_d;
    logic                tready_q, tready_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;

    logic accept;
    logic handshake;
    logic gap_enable;
    logic gap_expired;

    assign accept     = bus.s_axis_tvalid && tready_q;
    assign handshake  = valid_q && bus.cmd_ready;
    assign gap_enable = (state_q == ST_LEN) || (state_q == ST_DATA);

    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .resn   (resn),
        .clear  (accept),
        .enable (gap_enable),
        .expired(gap_expired)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        inc_d   = inc_q;
        addr_d  = addr_q;
        id_d    = id_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = bus.s_axis_tdata[WRITE_BIT];
                    inc_d   = bus.s_axis_tdata[INC_BIT];
                    addr_d  = bus.s_axis_tdata[ADDR_MSB:0];
                    id_d    = bus.s_axis_tid;
                    wdata_d = '0;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (bus.s_axis_tdata == '0) begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = bus.s_axis_tdata;
                        state_d = write_q ? ST_DATA : ST_ISSUE;
                    end
                end else if (gap_expired) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wdata_d = bus.s_axis_tdata;
                    state_d = ST_ISSUE;
                end else if (gap_expired) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    rem_d = rem_q - 8'd1;
                    if (inc_q) begin
                        addr_d = addr_q + 6'd1;
                    end
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end else if (write_q) begin
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        tready_d = (state_d != ST_ISSUE);
        valid_d  = (state_d == ST_ISSUE);
        last_d   = (state_d == ST_ISSUE) && (rem_d == 8'd1);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            inc_q    <= 1'b0;
            addr_q   <= '0;
            id_q     <= '0;
            wdata_q  <= '0;
            rem_q    <= '0;
            tready_q <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            inc_q    <= inc_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            wdata_q  <= wdata_d;
            rem_q    <= rem_d;
            tready_q <= tready_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.s_axis_tready = tready_q;
    assign bus.cmd_valid     = valid_q;
    assign bus.cmd_write     = write_q;
    assign bus.cmd_addr      = addr_q;
    assign bus.cmd_wdata     = wdata_q;
    assign bus.cmd_last      = last_q;
    assign bus.cmd_id        = id_q;
    assign frame_error       = ferr_q;
    assign busy              = busy_q;

endmodule
